// File: rtl/counter_timer_ctrl_if.sv
// Host-facing bundle of the counter/timer controller: request/config inputs and status outputs.
interface counter_timer_ctrl_if #(
    parameter int DWIDTH  = 7,
    parameter int PSWIDTH = 4
);
    logic               start_i;
    logic               stop_i;
    logic               pause_i;
    logic               mode_i;
    logic [DWIDTH-1:0]  cnt_val_i;
    logic [PSWIDTH-1:0] prescale_i;
    logic [DWIDTH-1:0]  cnt_o;
    logic               run_o;
    logic               done_o;
    logic               wrap_o;
    logic               busy_o;

    modport master (
        output start_i, stop_i, pause_i, mode_i, cnt_val_i, prescale_i,
        input  cnt_o, run_o, done_o, wrap_o, busy_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, mode_i, cnt_val_i, prescale_i,
        output cnt_o, run_o, done_o, wrap_o, busy_o
    );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Prescaled tick counter with IDLE/RUN/PAUSE/DONE control FSM, one-shot or periodic.
module counter_timer_ctrl #(
    parameter int DWIDTH  = 7,
    parameter int PSWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    counter_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DWIDTH-1:0]  cnt_q, cnt_d;
    logic [DWIDTH-1:0]  n_q, n_d;
    logic [PSWIDTH-1:0] ps_q, ps_d;
    logic [PSWIDTH-1:0] p_q, p_d;
    logic               mode_q, mode_d;
    logic               run_q, done_q, busy_q;

    logic [DWIDTH-1:0]  n_last;
    logic               tick;
    logic               last_step;
    logic               wrap;

    // n_last is only meaningful once a non-zero N has been latched
    assign n_last    = n_q - DWIDTH'(1);
    assign tick      = (ps_q == p_q);
    assign last_step = (cnt_q == n_last);
    assign wrap      = (state_q == ST_RUN) && !bus.stop_i && !bus.pause_i
                       && tick && last_step && mode_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        n_d     = n_q;
        p_d     = p_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    if (bus.cnt_val_i != '0) begin
                        n_d     = bus.cnt_val_i;
                        p_d     = bus.prescale_i;
                        mode_d  = bus.mode_i;
                        cnt_d   = '0;
                        ps_d    = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop_i) begin
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = ST_IDLE;
                end else if (bus.pause_i) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    ps_d = '0;
                    if (last_step) begin
                        cnt_d = '0;
                        if (!mode_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + DWIDTH'(1);
                    end
                end else begin
                    ps_d = ps_q + PSWIDTH'(1);
                end
            end
            ST_PAUSE: begin
                if (bus.stop_i) begin
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = ST_IDLE;
                end else if (!bus.pause_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ps_q    <= '0;
            n_q     <= '0;
            p_q     <= '0;
            mode_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            n_q     <= n_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            run_q   <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign bus.cnt_o  = cnt_q;
    assign bus.run_o  = run_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = busy_q;
    assign bus.wrap_o = wrap;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed bench: expected output tuples are queued with each stimulus step and checked per cycle.
module tb_counter_timer_ctrl;
    localparam int DW = 7;
    localparam int PW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    counter_timer_ctrl_if #(.DWIDTH(DW), .PSWIDTH(PW)) bus ();

    counter_timer_ctrl #(.DWIDTH(DW), .PSWIDTH(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW+3:0] v;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic run, input logic done,
                        input logic busy, input logic wrap, input int cnt);
        exp_t e;
        e.v   = {run, done, busy, wrap, DW'(cnt)};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic p_idle(input string t);                push(t, 1'b0, 1'b0, 1'b0, 1'b0, 0); endtask
    task automatic p_run(input string t, input int c, input logic w); push(t, 1'b1, 1'b0, 1'b1, w, c); endtask
    task automatic p_pause(input string t, input int c);  push(t, 1'b0, 1'b0, 1'b1, 1'b0, c); endtask
    task automatic p_done(input string t);                push(t, 1'b0, 1'b1, 1'b1, 1'b0, 0); endtask

    task automatic cmp_now();
        exp_t          e;
        logic [DW+3:0] obs;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed output with no expected entry");
        end else begin
            e   = exp_q.pop_front();
            obs = {bus.run_o, bus.done_o, bus.busy_o, bus.wrap_o, bus.cnt_o};
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s: run/done/busy/wrap/cnt observed %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                       e.tag, obs[DW+3], obs[DW+2], obs[DW+1], obs[DW], obs[DW-1:0],
                       e.v[DW+3], e.v[DW+2], e.v[DW+1], e.v[DW], e.v[DW-1:0]);
            end
        end
    endtask

    // compare mid-cycle, then advance to just after the next rising edge
    task automatic cyc();
        @(negedge clk);
        cmp_now();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) cyc();
    endtask

    task automatic drive(input logic st, input logic sp, input logic pa, input logic md,
                         input int n, input int p);
        bus.start_i    = st;
        bus.stop_i     = sp;
        bus.pause_i    = pa;
        bus.mode_i     = md;
        bus.cnt_val_i  = DW'(n);
        bus.prescale_i = PW'(p);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        p_idle("reset"); cmp_now();
        rst_n = 1'b1;

        // one-shot N=5 P=0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
        p_idle("t1_start"); cyc();
        bus.start_i = 1'b0;
        for (int c = 0; c < 5; c++) p_run("t1_run", c, 1'b0);
        p_done("t1_done"); p_idle("t1_idle");
        drain();

        // periodic N=3 P=1, then stop
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3, 1);
        p_idle("t2_start"); cyc();
        bus.start_i = 1'b0;
        for (int per = 0; per < 2; per++)
            for (int c = 0; c < 3; c++) begin
                p_run("t2_run", c, 1'b0);
                p_run("t2_run", c, (c == 2));
            end
        p_run("t2_run", 0, 1'b0); p_run("t2_run", 0, 1'b0); p_run("t2_run", 1, 1'b0);
        drain();
        bus.stop_i = 1'b1;
        p_run("t2_stopcyc", 1, 1'b0); cyc();
        bus.stop_i = 1'b0;
        p_idle("t2_stopped"); p_idle("t2_idle");
        drain();

        // maximum N, periodic, P=0
        drive(1'b1, 1'b0, 1'b0, 1'b1, 127, 0);
        p_idle("tmax_start"); cyc();
        bus.start_i = 1'b0;
        for (int c = 0; c < 127; c++) p_run("tmax_run", c, (c == 126));
        p_run("tmax_run", 0, 1'b0); p_run("tmax_run", 1, 1'b0);
        drain();
        bus.stop_i = 1'b1;
        p_run("tmax_stopcyc", 2, 1'b0); cyc();
        bus.stop_i = 1'b0;
        p_idle("tmax_idle"); drain();

        // N=1 with maximum prescale: 16 RUN cycles at cnt 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 15);
        p_idle("tps_start"); cyc();
        bus.start_i = 1'b0;
        for (int i = 0; i < 16; i++) p_run("tps_run", 0, 1'b0);
        p_done("tps_done"); p_idle("tps_idle");
        drain();

        // one-shot N=4 P=2, pause at cnt 2: 5 extra cycles before done
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4, 2);
        p_idle("t3_start"); cyc();
        bus.start_i = 1'b0;
        for (int c = 0; c < 2; c++) for (int i = 0; i < 3; i++) p_run("t3_run", c, 1'b0);
        drain();
        bus.pause_i = 1'b1;
        p_run("t3_pausecyc", 2, 1'b0); cyc();
        for (int i = 0; i < 3; i++) p_pause("t3_paused", 2);
        drain();
        bus.pause_i = 1'b0;
        p_pause("t3_resume", 2); cyc();
        for (int c = 2; c < 4; c++) for (int i = 0; i < 3; i++) p_run("t3_run", c, 1'b0);
        p_done("t3_done"); p_idle("t3_idle");
        drain();

        // zero-length request, then restart from DONE with N=2
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        p_idle("t4_start0"); cyc();
        bus.cnt_val_i = DW'(2);
        p_done("t4_done0"); cyc();
        bus.start_i = 1'b0;
        p_run("t4_run", 0, 1'b0); p_run("t4_run", 1, 1'b0);
        p_done("t4_done"); p_idle("t4_idle");
        drain();

        // start in RUN is ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6, 0);
        p_idle("t5_start"); cyc();
        bus.start_i = 1'b0;
        p_run("t5_run", 0, 1'b0); p_run("t5_run", 1, 1'b0); drain();
        bus.start_i = 1'b1; bus.cnt_val_i = DW'(2);
        p_run("t5_ign", 2, 1'b0); p_run("t5_ign", 3, 1'b0); drain();
        bus.start_i = 1'b0;
        p_run("t5_run", 4, 1'b0); p_run("t5_run", 5, 1'b0);
        p_done("t5_done"); p_idle("t5_idle");
        drain();

        // stop and pause together: stop wins
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
        p_idle("t5b_start"); cyc();
        bus.start_i = 1'b0;
        p_run("t5b_run", 0, 1'b0); p_run("t5b_run", 1, 1'b0); drain();
        bus.stop_i = 1'b1; bus.pause_i = 1'b1;
        p_run("t5b_both", 2, 1'b0); cyc();
        bus.stop_i = 1'b0; bus.pause_i = 1'b0;
        p_idle("t5b_stopped"); p_idle("t5b_idle");
        drain();

        // asynchronous reset mid-run at cnt 3
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8, 0);
        p_idle("t6_start"); cyc();
        bus.start_i = 1'b0;
        for (int c = 0; c < 3; c++) p_run("t6_run", c, 1'b0);
        drain();
        #2;
        p_run("t6_pre_rst", 3, 1'b0); cmp_now();
        rst_n = 1'b0;
        #1;
        p_idle("t6_async_rst"); cmp_now();
        @(posedge clk); #1;
        p_idle("t6_in_rst"); cmp_now();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) p_idle("t6_after_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
